// File: rtl/prescale_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : prescale_tick_gen
// Desc    : Two-stage cascaded prescaler producing one-cycle tick pulses, with
//           shadowed runtime divisors applied only on a period boundary or clr.
//           Define PRESCALE_SQ_EN to include the 50 % square-wave output.
// Rev     : 1.0  initial release
// ============================================================================
module prescale_tick_gen #(
    parameter int W1           = 14,
    parameter int W2           = 14,
    parameter int DEFAULT_DIV1 = 10000,
    parameter int DEFAULT_DIV2 = 10000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic          load,
    input  logic [W1-1:0] div1_in,
    input  logic [W2-1:0] div2_in,
    output logic          tick1,
    output logic          tick,
    output logic          sq,
    output logic          load_pending,
    output logic          load_ack
);

    localparam logic [W1-1:0] c_def_div1 = W1'(DEFAULT_DIV1);
    localparam logic [W2-1:0] c_def_div2 = W2'(DEFAULT_DIV2);

    logic [W1-1:0] r_cnt1;
    logic [W2-1:0] r_cnt2;
    logic [W1-1:0] r_d1;
    logic [W2-1:0] r_d2;
    logic [W1-1:0] r_s1;
    logic [W2-1:0] r_s2;
    logic          r_pending;
    logic          r_tick1;
    logic          r_tick;
    logic          r_load_ack;

    logic          w_hit1;
    logic          w_wrap;
    logic          w_apply;
    logic [W1-1:0] w_new_d1;
    logic [W2-1:0] w_new_d2;

    assign w_hit1  = en & (r_cnt1 == r_d1);
    assign w_wrap  = w_hit1 & (r_cnt2 == r_d2);
    assign w_apply = (w_wrap | clr) & (r_pending | load);

    // A load arriving in the applying cycle bypasses the shadow registers.
    assign w_new_d1 = load ? div1_in : r_s1;
    assign w_new_d2 = load ? div2_in : r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else if (clr) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
        end else if (en) begin
            if (w_hit1) begin
                r_cnt1 <= '0;
                if (r_cnt2 == r_d2) begin
                    r_cnt2 <= '0;
                end else begin
                    r_cnt2 <= r_cnt2 + 1'b1;
                end
            end else begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick1    <= 1'b0;
            r_tick     <= 1'b0;
            r_load_ack <= 1'b0;
        end else begin
            r_tick1    <= w_hit1 & ~clr;
            r_tick     <= w_wrap & ~clr;
            r_load_ack <= w_apply;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1      <= c_def_div1;
            r_d2      <= c_def_div2;
            r_s1      <= c_def_div1;
            r_s2      <= c_def_div2;
            r_pending <= 1'b0;
        end else begin
            if (load) begin
                r_s1 <= div1_in;
                r_s2 <= div2_in;
            end
            if (w_apply) begin
                r_d1      <= w_new_d1;
                r_d2      <= w_new_d2;
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef PRESCALE_SQ_EN
    logic r_sq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq <= 1'b0;
        end else if (clr) begin
            r_sq <= 1'b0;
        end else if (w_wrap) begin
            r_sq <= ~r_sq;
        end
    end

    assign sq = r_sq;
`else
    assign sq = 1'b0;
`endif

    assign tick1        = r_tick1;
    assign tick         = r_tick;
    assign load_pending = r_pending;
    assign load_ack     = r_load_ack;

endmodule
`default_nettype wire

// File: tb/tb_prescale_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_prescale_tick_gen
// Desc    : Directed self-checking bench for prescale_tick_gen (W1=W2=4,
//           defaults 3/2, i.e. 4-cycle tick1 and 12-cycle tick periods).
// Rev     : 1.0  initial release
// ============================================================================
module tb_prescale_tick_gen;

    localparam int W1   = 4;
    localparam int W2   = 4;
    localparam int DEF1 = 3;
    localparam int DEF2 = 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          en      = 1'b0;
    logic          clr     = 1'b0;
    logic          load    = 1'b0;
    logic [W1-1:0] div1_in = '0;
    logic [W2-1:0] div2_in = '0;
    logic          tick1;
    logic          tick;
    logic          sq;
    logic          load_pending;
    logic          load_ack;

    int checks = 0;
    int errors = 0;

    // Period-level expectation: enabled edges into the current final period.
    int m_d1, m_d2, m_s1, m_s2, m_ecnt;
    bit m_pend, m_sq;

    always #5 clk = ~clk;

    prescale_tick_gen #(
        .W1           (W1),
        .W2           (W2),
        .DEFAULT_DIV1 (DEF1),
        .DEFAULT_DIV2 (DEF2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr          (clr),
        .load         (load),
        .div1_in      (div1_in),
        .div2_in      (div2_in),
        .tick1        (tick1),
        .tick         (tick),
        .sq           (sq),
        .load_pending (load_pending),
        .load_ack     (load_ack)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit sq_exp();
`ifdef PRESCALE_SQ_EN
        return m_sq;
`else
        return 1'b0;
`endif
    endfunction

    // One clock edge with current inputs, then compare all outputs.
    task automatic step(input string tag);
        bit e_t1, e_t, e_ack;
        e_t1  = 1'b0;
        e_t   = 1'b0;
        e_ack = 1'b0;
        @(posedge clk);
        if (clr) begin
            m_ecnt = 0;
            m_sq   = 1'b0;
            e_ack  = m_pend || load;
        end else if (en) begin
            m_ecnt++;
            e_t1 = (m_ecnt % (m_d1 + 1)) == 0;
            if (m_ecnt == (m_d1 + 1) * (m_d2 + 1)) begin
                e_t    = 1'b1;
                m_ecnt = 0;
                m_sq   = ~m_sq;
                e_ack  = m_pend || load;
            end
        end
        if (e_ack) begin
            m_d1   = load ? int'(div1_in) : m_s1;
            m_d2   = load ? int'(div2_in) : m_s2;
            m_pend = 1'b0;
        end else if (load) begin
            m_pend = 1'b1;
        end
        if (load) begin
            m_s1 = int'(div1_in);
            m_s2 = int'(div2_in);
        end
        #1;
        check({tag, ".tick1"}, tick1, e_t1);
        check({tag, ".tick"}, tick, e_t);
        check({tag, ".sq"}, sq, sq_exp());
        check({tag, ".load_ack"}, load_ack, e_ack);
        check({tag, ".load_pending"}, load_pending, m_pend);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".tick1"}, tick1, 1'b0);
        check({tag, ".tick"}, tick, 1'b0);
        check({tag, ".sq"}, sq, 1'b0);
        check({tag, ".load_ack"}, load_ack, 1'b0);
        check({tag, ".load_pending"}, load_pending, 1'b0);
    endtask

    // Asserts reset between edges, holds it across two edges, releases it.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check_idle({tag, ".async"});
        repeat (2) @(posedge clk);
        #1;
        check_idle({tag, ".held"});
        m_d1   = DEF1;
        m_d2   = DEF2;
        m_s1   = DEF1;
        m_s2   = DEF2;
        m_pend = 1'b0;
        m_ecnt = 0;
        m_sq   = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic set_load(input int d1, input int d2);
        div1_in = W1'(d1);
        div2_in = W2'(d2);
        load    = 1'b1;
    endtask

    initial begin
        en = 1'b1;
        do_reset("rst");

        // Default periods: tick1 every 4, tick every 12, sq period 24.
        repeat (26) step("def");
        // Gate mid-period for five cycles.
        en = 1'b0;
        repeat (5) step("gate_off");
        en = 1'b1;
        repeat (10) step("gate_on");

        // Deferred load at cnt2=0: old 12-cycle period completes first.
        set_load(1, 1);
        step("defer_ld");
        load = 1'b0;
        repeat (11) step("defer_wait");
        repeat (8) step("defer_new");

        // Load exactly on the wrap cycle applies at once.
        repeat (3) step("coll_pre");
        set_load(2, 0);
        step("coll_wrap");
        load = 1'b0;
        repeat (6) step("coll_new");

        // Two loads before the wrap: last one wins (period 6, not 4).
        set_load(0, 3);
        step("dbl_ld1");
        set_load(1, 2);
        step("dbl_ld2");
        load = 1'b0;
        repeat (19) step("dbl_run");

        // Clear mid-period with a pending load.
        repeat (2) step("clr_pre");
        set_load(2, 1);
        step("clr_ld");
        load = 1'b0;
        step("clr_pend");
        clr = 1'b1;
        step("clr");
        clr = 1'b0;
        repeat (7) step("clr_new");

        // Zero divisors: both ticks every enabled cycle.
        set_load(0, 0);
        step("zero_ld");
        load = 1'b0;
        repeat (4) step("zero_wait");
        repeat (4) step("zero_run");
        en = 1'b0;
        repeat (2) step("zero_gate");

        // Pending load discarded by an asynchronous reset.
        set_load(5, 5);
        step("rst_pend");
        load = 1'b0;
        en   = 1'b1;
        do_reset("rst_mid1");
        repeat (5) step("rst_def1");
        do_reset("rst_mid2");
        repeat (25) step("rst_def2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
